// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with a one-word valid/ready holding register,
// sticky overflow, and an optional even-parity check (enabled by defining SIPO_PARITY_EN).
module sipo_deserializer #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MSB_FIRST = 1,
`ifdef SIPO_PARITY_EN
   localparam int unsigned FRAME    = WIDTH + 1,
`else
   localparam int unsigned FRAME    = WIDTH,
`endif
   localparam int unsigned CNT_W    = $clog2(FRAME) + 1
) (
   input  logic             Clk,
   input  logic             rst,
   input  logic             D,
   input  logic             d_valid,
   input  logic             frame_clr,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   input  logic             q_ready,
   output logic [CNT_W-1:0] bit_cnt,
   output logic             overflow,
   input  logic             ovf_clr,
   output logic             parity_err
);

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(FRAME - 1);

   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] word;
   logic             last;
   logic             free;

   always_comb begin
      shifted = sreg;
      if (MSB_FIRST != 0) begin
         shifted = {sreg[WIDTH-2:0], D};
      end else begin
         shifted = {D, sreg[WIDTH-1:1]};
      end
      last = d_valid && !frame_clr && (bit_cnt == LastCnt);
      free = !q_valid || q_ready;
`ifdef SIPO_PARITY_EN
      // The final bit of the frame is parity; the data bits are already in sreg.
      word = sreg;
`else
      word = shifted;
`endif
   end

   always_ff @(posedge Clk or negedge rst) begin
      if (!rst) begin
         sreg     <= '0;
         bit_cnt  <= '0;
         q        <= '0;
         q_valid  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (frame_clr) begin
            sreg    <= '0;
            bit_cnt <= '0;
         end else if (d_valid) begin
            if (last) begin
               sreg    <= '0;
               bit_cnt <= '0;
            end else begin
               sreg    <= shifted;
               bit_cnt <= bit_cnt + CNT_W'(1);
            end
         end

         if (last && free) begin
            q       <= word;
            q_valid <= 1'b1;
         end else if (q_valid && q_ready) begin
            q_valid <= 1'b0;
         end

         // Set wins over clear when both happen in one cycle.
         if (last && !free) begin
            overflow <= 1'b1;
         end else if (ovf_clr) begin
            overflow <= 1'b0;
         end
      end
   end

`ifdef SIPO_PARITY_EN
   logic par_bad;

   assign par_bad = (^sreg) ^ D;

   always_ff @(posedge Clk or negedge rst) begin
      if (!rst) begin
         parity_err <= 1'b0;
      end else if (last && free) begin
         parity_err <= par_bad;
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer: an MSB-first and an LSB-first instance share
// stimulus; expected words go through per-instance scoreboard queues.
module tb_sipo_deserializer;

`ifdef SIPO_PARITY_EN
   localparam int unsigned FRAME_TB = 9;
`else
   localparam int unsigned FRAME_TB = 8;
`endif
   localparam int unsigned CNT_W = $clog2(FRAME_TB) + 1;

   logic             Clk;
   logic             rst;
   logic             D;
   logic             d_valid;
   logic             frame_clr;
   logic             q_ready;
   logic             ovf_clr;
   logic [7:0]       q_m, q_l;
   logic             qv_m, qv_l;
   logic [CNT_W-1:0] cnt_m, cnt_l;
   logic             ovf_m, ovf_l;
   logic             perr_m, perr_l;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] exp_msb[$];
   logic [7:0] exp_lsb[$];
   logic       exp_perr[$];

   sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1)) dut (
      .Clk(Clk), .rst(rst), .D(D), .d_valid(d_valid), .frame_clr(frame_clr),
      .q(q_m), .q_valid(qv_m), .q_ready(q_ready), .bit_cnt(cnt_m),
      .overflow(ovf_m), .ovf_clr(ovf_clr), .parity_err(perr_m)
   );

   sipo_deserializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
      .Clk(Clk), .rst(rst), .D(D), .d_valid(d_valid), .frame_clr(frame_clr),
      .q(q_l), .q_valid(qv_l), .q_ready(q_ready), .bit_cnt(cnt_l),
      .overflow(ovf_l), .ovf_clr(ovf_clr), .parity_err(perr_l)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   task automatic send_bit(input logic b, input logic rdy);
      @(negedge Clk);
      D         = b;
      d_valid   = 1'b1;
      frame_clr = 1'b0;
      ovf_clr   = 1'b0;
      q_ready   = rdy;
      @(posedge Clk);
      #1;
   endtask

   task automatic idle(input logic rdy);
      @(negedge Clk);
      d_valid   = 1'b0;
      frame_clr = 1'b0;
      ovf_clr   = 1'b0;
      q_ready   = rdy;
      @(posedge Clk);
      #1;
   endtask

   // seq[7] is sent first; the frame ends with a parity bit when parity is built in.
   task automatic send_frame(input logic [7:0] seq, input logic bad_par, input logic expect_load,
                             input logic rdy_body, input logic rdy_last);
      logic       par;
      logic [7:0] em, el;
      logic       ep;
      par = (^seq) ^ bad_par;
      if (expect_load) begin
         exp_msb.push_back(seq);
         exp_lsb.push_back(rev8(seq));
`ifdef SIPO_PARITY_EN
         exp_perr.push_back(bad_par);
`else
         exp_perr.push_back(1'b0);
`endif
      end
`ifdef SIPO_PARITY_EN
      for (int i = 7; i >= 0; i--) send_bit(seq[i], rdy_body);
      send_bit(par, rdy_last);
`else
      for (int i = 7; i >= 1; i--) send_bit(seq[i], rdy_body);
      send_bit(seq[0], rdy_last);
`endif
      n_checks++;
      if (cnt_m !== '0 || cnt_l !== '0) begin
         n_fail++;
         $display("FAIL frame_cnt_wrap: got %0d/%0d want 0", cnt_m, cnt_l);
      end
      if (expect_load) begin
         em = exp_msb.pop_front();
         el = exp_lsb.pop_front();
         ep = exp_perr.pop_front();
         n_checks++;
         if (q_m !== em) begin
            n_fail++;
            $display("FAIL q_msb: got %h want %h", q_m, em);
         end
         n_checks++;
         if (q_l !== el) begin
            n_fail++;
            $display("FAIL q_lsb: got %h want %h", q_l, el);
         end
         n_checks++;
         if (qv_m !== 1'b1 || qv_l !== 1'b1) begin
            n_fail++;
            $display("FAIL q_valid_load: got %b/%b want 1", qv_m, qv_l);
         end
         n_checks++;
         if (perr_m !== ep || perr_l !== ep) begin
            n_fail++;
            $display("FAIL parity_err: got %b/%b want %b", perr_m, perr_l, ep);
         end
      end
   endtask

   task automatic test_reset;
      n_checks++;
      if (q_m !== 8'h00 || q_l !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_q: got %h/%h want 00", q_m, q_l);
      end
      n_checks++;
      if (qv_m !== 1'b0 || qv_l !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_q_valid: got %b/%b want 0", qv_m, qv_l);
      end
      n_checks++;
      if (cnt_m !== '0 || ovf_m !== 1'b0 || perr_m !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_misc: got cnt=%0d ovf=%b perr=%b want 0", cnt_m, ovf_m, perr_m);
      end
      @(negedge Clk);
      rst = 1'b1;
   endtask

   task automatic test_msb_lsb;
      for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1);
      n_checks++;
      if (cnt_m !== CNT_W'(5)) begin
         n_fail++;
         $display("FAIL bit_cnt_mid: got %0d want 5", cnt_m);
      end
      @(negedge Clk);
      frame_clr = 1'b1;
      d_valid   = 1'b0;
      @(posedge Clk);
      #1;
      send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b1);
      send_frame(8'hC0, 1'b0, 1'b1, 1'b1, 1'b1);
   endtask

   task automatic test_overflow;
      idle(1'b1);
      n_checks++;
      if (qv_m !== 1'b0) begin
         n_fail++;
         $display("FAIL consume_drop_valid: got %b want 0", qv_m);
      end
      send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
      send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (ovf_m !== 1'b1 || ovf_l !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_set: got %b/%b want 1", ovf_m, ovf_l);
      end
      n_checks++;
      if (q_m !== 8'h11 || q_l !== 8'h88 || qv_m !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_hold: got %h/%h v=%b want 11/88 v=1", q_m, q_l, qv_m);
      end
      @(negedge Clk);
      d_valid = 1'b0;
      ovf_clr = 1'b1;
      @(posedge Clk);
      #1;
      n_checks++;
      if (ovf_m !== 1'b0 || q_m !== 8'h11) begin
         n_fail++;
         $display("FAIL ovf_clr: got ovf=%b q=%h want ovf=0 q=11", ovf_m, q_m);
      end
   endtask

   task automatic test_consume_load;
      send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b1);
      n_checks++;
      if (ovf_m !== 1'b0) begin
         n_fail++;
         $display("FAIL consume_load_ovf: got %b want 0", ovf_m);
      end
      idle(1'b1);
      n_checks++;
      if (qv_m !== 1'b0 || q_m !== 8'h22) begin
         n_fail++;
         $display("FAIL consume_after: got v=%b q=%h want v=0 q=22", qv_m, q_m);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] w;
      for (int k = 0; k < 4; k++) begin
         w = 8'($urandom_range(0, 255));
         send_frame(w, 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b1);
      end
      n_checks++;
      if (ovf_m !== 1'b0 || ovf_l !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_overflow: got %b/%b want 0", ovf_m, ovf_l);
      end
   endtask

   task automatic test_frame_clr;
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
      @(negedge Clk);
      D         = 1'b1;
      d_valid   = 1'b1;
      frame_clr = 1'b1;
      @(posedge Clk);
      #1;
      n_checks++;
      if (cnt_m !== '0) begin
         n_fail++;
         $display("FAIL frame_clr_cnt: got %0d want 0", cnt_m);
      end
      send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b1);
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
      @(negedge Clk);
      d_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      n_checks++;
      if (q_m !== 8'h00 || qv_m !== 1'b0 || cnt_m !== '0 || ovf_m !== 1'b0 || perr_m !== 1'b0)
      begin
         n_fail++;
         $display("FAIL reset_mid: got q=%h v=%b cnt=%0d ovf=%b perr=%b want all 0",
                  q_m, qv_m, cnt_m, ovf_m, perr_m);
      end
      @(negedge Clk);
      rst = 1'b1;
      send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b1);
   endtask

   task automatic test_parity;
      send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b1);
      send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);
      send_frame(8'h0F, 1'b0, 1'b1, 1'b1, 1'b1);
   endtask

   initial begin
      rst       = 1'b0;
      D         = 1'b0;
      d_valid   = 1'b0;
      frame_clr = 1'b0;
      q_ready   = 1'b1;
      ovf_clr   = 1'b0;
      #12;
      test_reset;
      test_msb_lsb;
      test_overflow;
      test_consume_load;
      test_back_to_back;
      test_frame_clr;
      test_reset_mid;
      test_parity;
      idle(1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
